csr_file_m: RTL and testbench

CSR_FILE_M -- requirements
Module: csr_file_m

---
 rtl/csr_pkg.sv | 59 +++++
 rtl/csr_counter64.sv | 29 ++
 rtl/csr_file_m.sv | 210 +++++++++++++++++++++
 tb/tb_csr_file_m.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR constants: address map, operation encodings, status/interrupt
// bit positions and the read-modify-write helper used by the CSR file.
package csr_pkg;

  // Machine-mode CSR address map
  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MISA       = 12'h301;
  localparam logic [11:0] CSR_MIE        = 12'h304;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MIP        = 12'h344;
  localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
  localparam logic [11:0] CSR_MARCHID    = 12'hF12;
  localparam logic [11:0] CSR_MIMPID     = 12'hF13;
  localparam logic [11:0] CSR_MHARTID    = 12'hF14;

  // CSR access operations
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Bit positions inside mstatus / mie / mip / mtvec
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MEIE       = 11;
  localparam int MIP_MEIP       = 11;
  localparam int MTVEC_MODE     = 0;

  // Counter indices inside the counter bank
  localparam int CNT_CYCLE   = 0;
  localparam int CNT_INSTRET = 1;
  localparam int CNT_NUM     = 2;

  // New CSR value produced by an access given the old value and the operand
  function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                               input logic [31:0] old_value,
                                               input logic [31:0] operand);
    logic [31:0] result;
    case (op)
      CSR_OP_RW: result = operand;
      CSR_OP_RS: result = old_value | operand;
      CSR_OP_RC: result = old_value & ~operand;
      default:   result = old_value;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent loads of each 32-bit half.
// Any load takes precedence over the increment for the whole counter.
module csr_counter64 (
  input  logic        clk,
  input  logic        srst,
  input  logic        en,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic [31:0] load_value,
  output logic [63:0] count
);

  logic [63:0] count_reg;

  // Load the addressed half, otherwise count up when enabled (wraps at 2^64)
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load_lo || load_hi) begin
      if (load_lo) count_reg[31:0]  <= load_value;
      if (load_hi) count_reg[63:32] <= load_value;
    end else if (en) begin
      count_reg <= count_reg + 64'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: registered CSR read/modify/write port, trap entry
// and return bookkeeping, external interrupt pending logic and the
// mcycle/minstret counters.
module csr_file_m
  import csr_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  HART_ID    = '0,
  parameter logic [XLEN-1:0]  MISA_VALUE = 32'h4000_0100
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [1:0]      csr_op_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            illegal_o,
  input  logic            instret_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            irq_ext_i,
  output logic [XLEN-1:0] trap_target_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending_o
);

  csr_op_e         op;
  logic            op_active;
  logic            wants_write;
  logic            addr_valid;
  logic            addr_ro;
  logic            access_illegal;
  logic            write_en;
  logic [XLEN-1:0] old_value;
  logic [XLEN-1:0] new_value;
  logic [XLEN-1:0] mstatus_value;

  logic            mie_bit_reg;
  logic            mpie_bit_reg;
  logic            meie_reg;
  logic            meip_reg;
  logic [XLEN-1:0] mtvec_reg;
  logic [XLEN-1:0] mcounteren_reg;
  logic [XLEN-1:0] mepc_reg;
  logic [XLEN-1:0] mcause_reg;
  logic [XLEN-1:0] rdata_reg;
  logic            illegal_reg;

  logic [CNT_NUM-1:0] cnt_en;
  logic [CNT_NUM-1:0] cnt_load_lo;
  logic [CNT_NUM-1:0] cnt_load_hi;
  logic [63:0]        cnt_value [CNT_NUM];

  assign op        = csr_op_e'(csr_op_i);
  assign op_active = (op != CSR_OP_NONE);
  // RS/RC with a zero operand cannot change anything, so they are pure reads
  // and must not disturb read-only registers or the counters' increment.
  assign wants_write = (op == CSR_OP_RW) ||
                       (op_active && (csr_wdata_i != '0));

  // Assemble the architectural mstatus view; MPP is hardwired to machine mode
  always_comb begin
    mstatus_value                               = '0;
    mstatus_value[MSTATUS_MIE]                  = mie_bit_reg;
    mstatus_value[MSTATUS_MPIE]                 = mpie_bit_reg;
    mstatus_value[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // Decode the address into the current value and its access class
  always_comb begin
    old_value  = '0;
    addr_valid = 1'b1;
    addr_ro    = 1'b0;
    case (csr_addr_i)
      CSR_MISA:       old_value = MISA_VALUE;
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:     addr_ro = 1'b1;
      CSR_MHARTID: begin
        old_value = HART_ID;
        addr_ro   = 1'b1;
      end
      CSR_MSTATUS:    old_value = mstatus_value;
      CSR_MIE:        old_value[MIE_MEIE] = meie_reg;
      CSR_MTVEC:      old_value = mtvec_reg;
      CSR_MCOUNTEREN: old_value = mcounteren_reg;
      CSR_MEPC:       old_value = mepc_reg;
      CSR_MCAUSE:     old_value = mcause_reg;
      CSR_MIP:        old_value[MIP_MEIP] = meip_reg;
      CSR_MCYCLE:     old_value = cnt_value[CNT_CYCLE][31:0];
      CSR_MCYCLEH:    old_value = cnt_value[CNT_CYCLE][63:32];
      CSR_MINSTRET:   old_value = cnt_value[CNT_INSTRET][31:0];
      CSR_MINSTRETH:  old_value = cnt_value[CNT_INSTRET][63:32];
      default:        addr_valid = 1'b0;
    endcase
  end

  assign access_illegal = op_active && (!addr_valid || (addr_ro && wants_write));
  // Trap entry and mret both win over a software write in the same cycle
  assign write_en  = wants_write && !access_illegal && !trap_i && !mret_i;
  assign new_value = csr_apply_op(op, old_value, csr_wdata_i);

  // Registered read port: old value and illegal flag, held while idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_reg   <= '0;
      illegal_reg <= 1'b0;
    end else if (op_active) begin
      rdata_reg   <= old_value;
      illegal_reg <= access_illegal;
    end else begin
      illegal_reg <= 1'b0;
    end
  end

  // mstatus interrupt-enable stack: trap pushes, mret pops, else software write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_bit_reg  <= 1'b0;
      mpie_bit_reg <= 1'b0;
    end else if (trap_i) begin
      mpie_bit_reg <= mie_bit_reg;
      mie_bit_reg  <= 1'b0;
    end else if (mret_i) begin
      mie_bit_reg  <= mpie_bit_reg;
      mpie_bit_reg <= 1'b1;
    end else if (write_en && (csr_addr_i == CSR_MSTATUS)) begin
      mie_bit_reg  <= new_value[MSTATUS_MIE];
      mpie_bit_reg <= new_value[MSTATUS_MPIE];
    end
  end

  // Trap state: mepc keeps instruction alignment, mcause takes the full value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mepc_reg   <= '0;
      mcause_reg <= '0;
    end else if (trap_i) begin
      mepc_reg   <= {trap_pc_i[XLEN-1:2], 2'b00};
      mcause_reg <= trap_cause_i;
    end else if (write_en) begin
      if (csr_addr_i == CSR_MEPC)   mepc_reg   <= {new_value[XLEN-1:2], 2'b00};
      if (csr_addr_i == CSR_MCAUSE) mcause_reg <= new_value;
    end
  end

  // Plain software-writable configuration registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtvec_reg      <= '0;
      mcounteren_reg <= '0;
      meie_reg       <= 1'b0;
    end else if (write_en) begin
      if (csr_addr_i == CSR_MTVEC)
        mtvec_reg <= {new_value[XLEN-1:2], 1'b0, new_value[MTVEC_MODE]};
      if (csr_addr_i == CSR_MCOUNTEREN)
        mcounteren_reg <= new_value;
      if (csr_addr_i == CSR_MIE)
        meie_reg <= new_value[MIE_MEIE];
    end
  end

  // External interrupt level sampled into mip.MEIP
  always_ff @(posedge clk_i) begin
    if (rst_i) meip_reg <= 1'b0;
    else       meip_reg <= irq_ext_i;
  end

  // Counter controls: cycle counter always runs, instret on retirement
  always_comb begin
    cnt_en                   = '0;
    cnt_en[CNT_CYCLE]        = 1'b1;
    cnt_en[CNT_INSTRET]      = instret_i;
    cnt_load_lo              = '0;
    cnt_load_hi              = '0;
    cnt_load_lo[CNT_CYCLE]   = write_en && (csr_addr_i == CSR_MCYCLE);
    cnt_load_hi[CNT_CYCLE]   = write_en && (csr_addr_i == CSR_MCYCLEH);
    cnt_load_lo[CNT_INSTRET] = write_en && (csr_addr_i == CSR_MINSTRET);
    cnt_load_hi[CNT_INSTRET] = write_en && (csr_addr_i == CSR_MINSTRETH);
  end

  generate
    for (genvar gi = 0; gi < CNT_NUM; gi++) begin : g_counter
      csr_counter64 u_counter (
        .clk        (clk_i),
        .srst       (rst_i),
        .en         (cnt_en[gi]),
        .load_lo    (cnt_load_lo[gi]),
        .load_hi    (cnt_load_hi[gi]),
        .load_value (new_value),
        .count      (cnt_value[gi])
      );
    end
  endgenerate

  // Vectored mode offsets interrupts by 4*cause; exceptions use the base
  always_comb begin
    trap_target_o = {mtvec_reg[XLEN-1:2], 2'b00};
    if (mtvec_reg[MTVEC_MODE] && trap_cause_i[XLEN-1])
      trap_target_o = trap_target_o + {trap_cause_i[XLEN-3:0], 2'b00};
  end

  assign irq_pending_o = mie_bit_reg & meie_reg & meip_reg;
  assign mepc_o        = mepc_reg;
  assign csr_rdata_o   = rdata_reg;
  assign illegal_o     = illegal_reg;

endmodule

// File: tb/tb_csr_file_m.sv
// Self-checking bench for csr_file_m: a vector table of single CSR accesses
// plus hand-written sequences for traps, interrupts, counters and reset.
module tb_csr_file_m;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;
  localparam logic [31:0] TB_HART = 32'h0000_0007;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_addr = '0;
  logic [1:0]  csr_op = OP_NONE;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        illegal;
  logic        instret = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_pc = '0;
  logic        mret = 1'b0;
  logic        irq_ext = 1'b0;
  logic [31:0] trap_target;
  logic [31:0] mepc;
  logic        irq_pending;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ill;
    bit          chk_rd;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        ill;
    bit          chk_rd;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[28];

  csr_file_m #(
    .XLEN       (32),
    .HART_ID    (TB_HART),
    .MISA_VALUE (32'h4000_0100)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .csr_addr_i    (csr_addr),
    .csr_op_i      (csr_op),
    .csr_wdata_i   (csr_wdata),
    .csr_rdata_o   (csr_rdata),
    .illegal_o     (illegal),
    .instret_i     (instret),
    .trap_i        (trap),
    .trap_cause_i  (trap_cause),
    .trap_pc_i     (trap_pc),
    .mret_i        (mret),
    .irq_ext_i     (irq_ext),
    .trap_target_o (trap_target),
    .mepc_o        (mepc),
    .irq_pending_o (irq_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One CSR access: drive at negedge, push expectation, compare after the edge
  task automatic issue(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                       input logic [31:0] er, input logic ei, input bit cr, input string nm);
    exp_t e;
    @(negedge clk);
    csr_addr  = a;
    csr_op    = op;
    csr_wdata = wd;
    e.name = nm; e.rdata = er; e.ill = ei; e.chk_rd = cr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    csr_op = OP_NONE;
    e = sb_q.pop_front();
    $display("[TB] %s addr=%h op=%0d wdata=%h rdata=%h illegal=%b",
             e.name, a, op, wd, csr_rdata, illegal);
    if (e.chk_rd) check({e.name, ".rdata"}, csr_rdata, e.rdata);
    check({e.name, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
  endtask

  initial begin
    vecs[0]  = '{12'h301, OP_RS, 32'h0,         32'h4000_0100, 1'b0, 1'b1};
    vecs[1]  = '{12'h301, OP_RW, 32'h0,         32'h4000_0100, 1'b0, 1'b1};
    vecs[2]  = '{12'h301, OP_RS, 32'h0,         32'h4000_0100, 1'b0, 1'b1};
    vecs[3]  = '{12'hF11, OP_RS, 32'h0,         32'h0,         1'b0, 1'b1};
    vecs[4]  = '{12'h305, OP_RW, 32'h8000_0003, 32'h0,         1'b0, 1'b1};
    vecs[5]  = '{12'h305, OP_RS, 32'h0,         32'h8000_0001, 1'b0, 1'b1};
    vecs[6]  = '{12'hF14, OP_RW, 32'h5,         32'h0,         1'b1, 1'b0};
    vecs[7]  = '{12'hF14, OP_RS, 32'h0,         TB_HART,       1'b0, 1'b1};
    vecs[8]  = '{12'hF14, OP_RC, 32'h1,         32'h0,         1'b1, 1'b0};
    vecs[9]  = '{12'h123, OP_RW, 32'h55,        32'h0,         1'b1, 1'b1};
    vecs[10] = '{12'h341, OP_RW, 32'h1237,      32'h0,         1'b0, 1'b1};
    vecs[11] = '{12'h341, OP_RS, 32'h0,         32'h1234,      1'b0, 1'b1};
    vecs[12] = '{12'h300, OP_RW, 32'hFFFF_FFFF, 32'h1800,      1'b0, 1'b1};
    vecs[13] = '{12'h300, OP_RS, 32'h0,         32'h1888,      1'b0, 1'b1};
    vecs[14] = '{12'h300, OP_RC, 32'h8,         32'h1888,      1'b0, 1'b1};
    vecs[15] = '{12'h300, OP_RS, 32'h0,         32'h1880,      1'b0, 1'b1};
    vecs[16] = '{12'h304, OP_RW, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1};
    vecs[17] = '{12'h304, OP_RS, 32'h0,         32'h800,       1'b0, 1'b1};
    vecs[18] = '{12'h344, OP_RW, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1};
    vecs[19] = '{12'h344, OP_RS, 32'h0,         32'h0,         1'b0, 1'b1};
    vecs[20] = '{12'h342, OP_RW, 32'h8000_000B, 32'h0,         1'b0, 1'b1};
    vecs[21] = '{12'h342, OP_RS, 32'h0,         32'h8000_000B, 1'b0, 1'b1};
    vecs[22] = '{12'h306, OP_RW, 32'h5,         32'h0,         1'b0, 1'b1};
    vecs[23] = '{12'h306, OP_RS, 32'h0,         32'h5,         1'b0, 1'b1};
    vecs[24] = '{12'h123, OP_NONE, 32'h0,       32'h5,         1'b0, 1'b1};
    vecs[25] = '{12'h7C0, OP_RC, 32'h3,         32'h0,         1'b1, 1'b1};
    vecs[26] = '{12'h7C0, OP_NONE, 32'h0,       32'h0,         1'b0, 1'b1};
    vecs[27] = '{12'hF11, OP_RW, 32'h0,         32'h0,         1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.rdata", csr_rdata, 32'h0);
    check("reset.illegal", {31'd0, illegal}, 32'h0);
    check("reset.trap_target", trap_target, 32'h0);
    check("reset.irq_pending", {31'd0, irq_pending}, 32'h0);
    check("reset.mepc", mepc, 32'h0);
    rst = 1'b0;

    // Table of single accesses
    for (int i = 0; i < 28; i++)
      issue(vecs[i].addr, vecs[i].op, vecs[i].wdata, vecs[i].rdata, vecs[i].ill,
            vecs[i].chk_rd, $sformatf("vec%0d", i));

    // Vectored trap target (mtvec = 0x8000_0001)
    @(negedge clk);
    trap_cause = 32'h8000_000B;
    #1 check("target.vectored_irq", trap_target, 32'h8000_002C);
    trap_cause = 32'h0000_0002;
    #1 check("target.exception", trap_target, 32'h8000_0000);

    // Trap entry and mret
    issue(12'h300, OP_RW, 32'h8, 32'h1880, 1'b0, 1'b1, "set_mie");
    @(negedge clk);
    trap = 1'b1; trap_pc = 32'h0000_1236; trap_cause = 32'h2;
    @(posedge clk);
    #1 trap = 1'b0;
    check("trap.mepc", mepc, 32'h0000_1234);
    issue(12'h342, OP_RS, 32'h0, 32'h2, 1'b0, 1'b1, "trap.mcause");
    issue(12'h300, OP_RS, 32'h0, 32'h1880, 1'b0, 1'b1, "trap.mstatus");
    @(negedge clk);
    mret = 1'b1;
    @(posedge clk);
    #1 mret = 1'b0;
    issue(12'h300, OP_RS, 32'h0, 32'h1888, 1'b0, 1'b1, "mret.mstatus");

    // External interrupt: MEIP is registered, pending needs MIE & MEIE
    @(negedge clk);
    irq_ext = 1'b1;
    #1 check("irq.before_edge", {31'd0, irq_pending}, 32'h0);
    @(posedge clk);
    #1 check("irq.pending", {31'd0, irq_pending}, 32'h1);
    issue(12'h344, OP_RS, 32'h0, 32'h800, 1'b0, 1'b1, "irq.mip");

    // trap + mret + mstatus write in one cycle: only the trap takes effect
    trap = 1'b1; mret = 1'b1; trap_pc = 32'h0000_2002; trap_cause = 32'h3;
    issue(12'h300, OP_RW, 32'h8, 32'h1888, 1'b0, 1'b1, "prio.access");
    trap = 1'b0; mret = 1'b0;
    check("prio.mepc", mepc, 32'h0000_2000);
    check("prio.irq_pending", {31'd0, irq_pending}, 32'h0);
    issue(12'h300, OP_RS, 32'h0, 32'h1880, 1'b0, 1'b1, "prio.mstatus");
    issue(12'h342, OP_RS, 32'h0, 32'h3, 1'b0, 1'b1, "prio.mcause");

    // mcycle wrap: high then low written on consecutive cycles
    issue(12'hB80, OP_RW, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, "cyc.wr_hi");
    issue(12'hB00, OP_RW, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, "cyc.wr_lo");
    issue(12'hB00, OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0, "cyc.idle");
    issue(12'hB00, OP_RS, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, "cyc.max");
    issue(12'hB00, OP_RS, 32'h0, 32'h0, 1'b0, 1'b1, "cyc.wrapped");
    issue(12'hB80, OP_RS, 32'h0, 32'h0, 1'b0, 1'b1, "cyc.hi_wrapped");

    // minstret: write suppresses the increment, then counts retirements only
    instret = 1'b1;
    issue(12'hB02, OP_RW, 32'd10, 32'h0, 1'b0, 1'b0, "ins.wr");
    instret = 1'b0;
    issue(12'hB02, OP_RS, 32'h0, 32'd10, 1'b0, 1'b1, "ins.after_wr");
    instret = 1'b1;
    issue(12'hB02, OP_RS, 32'h0, 32'd10, 1'b0, 1'b1, "ins.retire");
    instret = 1'b0;
    issue(12'hB02, OP_RS, 32'h0, 32'd11, 1'b0, 1'b1, "ins.counted");
    issue(12'hB82, OP_RS, 32'h0, 32'h0, 1'b0, 1'b1, "ins.hi");

    // Reset wins over a simultaneous trap and CSR write
    @(negedge clk);
    rst = 1'b1; trap = 1'b1; trap_pc = 32'h0000_4444; trap_cause = 32'h8000_000B;
    csr_addr = 12'h305; csr_op = OP_RW; csr_wdata = 32'h1234_5679;
    @(posedge clk);
    #1;
    rst = 1'b0; trap = 1'b0; csr_op = OP_NONE;
    check("rst.rdata", csr_rdata, 32'h0);
    check("rst.illegal", {31'd0, illegal}, 32'h0);
    check("rst.mepc", mepc, 32'h0);
    check("rst.trap_target", trap_target, 32'h0);
    check("rst.irq_pending", {31'd0, irq_pending}, 32'h0);
    issue(12'h300, OP_RS, 32'h0, 32'h1800, 1'b0, 1'b1, "rst.mstatus");
    issue(12'h305, OP_RS, 32'h0, 32'h0, 1'b0, 1'b1, "rst.mtvec");
    issue(12'h304, OP_RS, 32'h0, 32'h0, 1'b0, 1'b1, "rst.mie");
    issue(12'h342, OP_RS, 32'h0, 32'h0, 1'b0, 1'b1, "rst.mcause");
    issue(12'h306, OP_RS, 32'h0, 32'h0, 1'b0, 1'b1, "rst.mcounteren");
    issue(12'hB02, OP_RS, 32'h0, 32'h0, 1'b0, 1'b1, "rst.minstret");
    issue(12'hB80, OP_RS, 32'h0, 32'h0, 1'b0, 1'b1, "rst.mcycleh");
    issue(12'h344, OP_RS, 32'h0, 32'h800, 1'b0, 1'b1, "rst.mip");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
